seq_mult: RTL
=============

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port sgn  input  1  1 = operands are two's complement, 0 = operands are unsigned; sampled with start.
REQ-006 The block SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 The block SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 The block SHALL have port busy  output  1  high while a multiply is in progress (CALC or DONE).
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking a valid product.
REQ-010 The block SHALL have port product  output  2*WIDTH  registered result; held until the next done.

Function
REQ-011 The block SHALL be an FSM with states IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture the operand magnitudes (negate when sgn=1 and MSB=1), the result sign (a[MSB]^b[MSB] when sgn=1, else 0) and the bit count, and SHALL enter CALC.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-014 CALC SHALL process one multiplier bit per cycle, LSB first: add the shifted multiplicand magnitude to a 2*WIDTH accumulator when the bit is 1, then shift the multiplicand left and the multiplier right.
REQ-015 After WIDTH CALC cycles, the block SHALL enter DONE; product SHALL be loaded with the accumulator, two's-complement negated when the result sign is 1.
REQ-016 The block SHALL drive done=1 for exactly one cycle (DONE) and SHALL then return to IDLE, so done is high in cycle k+WIDTH+1 and start is accepted again at edge k+WIDTH+2.
REQ-017 The block SHALL ignore start while busy=1; captured operands SHALL NOT change mid-operation.
REQ-018 The block SHALL treat an operand magnitude as an unsigned WIDTH-bit value, so the most-negative operand (e.g. -128 at WIDTH=8) SHALL produce an exact result.
REQ-019 The block SHALL return a zero product with a sign of 1 (e.g. -5*0) as 0, never as a nonzero value.
REQ-020 The block SHALL hold product stable everywhere except the cycle in which DONE is entered.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL force state=IDLE, busy=0, done=0, product=0 and clear the accumulator, operands, sign and count.
REQ-022 The block SHALL give rst priority over start and over every state transition.
REQ-023 A reset during CALC or DONE SHALL abort the operation without producing a done pulse.

Configuration
REQ-024 When the macro SEQ_MULT_EARLY_TERM_EN is defined, CALC SHALL go to DONE at the end of any cycle in which the remaining shifted multiplier is zero, giving a latency of (index of the highest set multiplier magnitude bit + 1) CALC cycles, with a minimum of 1.
REQ-025 When the macro SEQ_MULT_EARLY_TERM_EN is undefined, CALC SHALL always last exactly WIDTH cycles.
REQ-026 The product value SHALL be identical with and without SEQ_MULT_EARLY_TERM_EN.

Structure
REQ-027 The shared package seq_mult_pkg SHALL hold the state typedef (IDLE, CALC, DONE) and the default-width constant.
REQ-028 The block SHALL use one sub-module, cond_negate, parameterised by width (conditional two's-complement), instantiated for the a and b magnitudes and for the final product.
REQ-029 The block SHALL have no combinational path from an input to an output.

Verification
REQ-030 The bench SHALL cover: WIDTH=8, sgn=1, a=-3 (0xFD), b=7 -> done in cycle k+9, product=0xFFEB (-21), busy high for cycles k+1..k+9.
REQ-031 The bench SHALL cover: WIDTH=8, sgn=0, a=0xFF, b=0xFF -> product=0xFE01 (65025); and sgn=1 with the same operands -> product=0x0001.
REQ-032 The bench SHALL cover: WIDTH=8, sgn=1, a=0x80, b=0x80 -> product=0x4000; and a=0x80, b=0x01 -> product=0xFF80.
REQ-033 The bench SHALL cover: start held high continuously with a changed mid-CALC -> the first result uses the original operands, and the next operation starts only after DONE.
REQ-034 The bench SHALL cover: rst asserted in the third CALC cycle -> no done pulse, product=0, busy=0 on the next cycle, and a fresh start then completes correctly.
REQ-035 The bench SHALL cover: with SEQ_MULT_EARLY_TERM_EN defined, a=5, b=2 -> done after 2 CALC cycles with product=10; and b=0 -> 1 CALC cycle with product=0.

Source files
------------

// File: rtl/seq_mult_pkg.sv
//==============================================================================
// Module      : seq_mult_pkg
// Description : Shared state encoding and default operand width for seq_mult.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_mult_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cond_negate.sv
//==============================================================================
// Module      : cond_negate
// Description : Conditional two's-complement negation of a WIDTH-bit value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cond_negate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
//==============================================================================
// Module      : seq_mult
// Description : Shift-and-add sequential multiplier, signed or unsigned,
//               one multiplier bit per cycle. Optional early termination
//               when the macro SEQ_MULT_EARLY_TERM_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned c_CW = $clog2(WIDTH);

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit c_EARLY_TERM = 1'b1;
`else
    localparam bit c_EARLY_TERM = 1'b0;
`endif

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod_signed;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     w_mplier_next;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 r_sign;
    logic [c_CW-1:0]      r_count;
    logic                 w_last;

    // Magnitudes are unsigned WIDTH-bit, so the most-negative operand is exact
    cond_negate #(.WIDTH(WIDTH)) u_neg_a (
        .din  (a),
        .neg  (sgn & a[WIDTH-1]),
        .dout (w_mag_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_neg_b (
        .din  (b),
        .neg  (sgn & b[WIDTH-1]),
        .dout (w_mag_b)
    );

    cond_negate #(.WIDTH(2*WIDTH)) u_neg_p (
        .din  (w_acc_next),
        .neg  (r_sign),
        .dout (w_prod_signed)
    );

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;
    assign w_last        = (r_count == '0) || (c_EARLY_TERM && (w_mplier_next == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_count  <= '0;
            product  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_sign   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= c_CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count - c_CW'(1);
                    // Final accumulation folds straight into the product load
                    if (w_last) begin
                        product <= w_prod_signed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
